i2c_line_bridge_n: RTL
======================

I2C_LINE_BRIDGE_N -- requirements
Module: i2c_line_bridge_n

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  N_PORTS, 2: open-drain ports joined on one line (SDA or SCL); legal 2..8.
  DIV, 6: clk cycles per internal tick; legal >= 2.
  FILT, 2: consecutive ticks of agreement before a filtered level changes; legal 1..15.
  HOLD, 3: ticks all ports stay released after the owner lets go; legal 1..15.
  TIMEOUT, 4096: owner-low ticks before the line is declared stuck; 0 disables the timeout.
REQ-002 OW SHALL be the width of owner, equal to max(1, clog2(N_PORTS)).
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1: single clock.
  rst_n, in, 1: asynchronous reset, active-low.
  en, in, N_PORTS: per-port enable.
  i, in, N_PORTS: pad levels, asynchronous to clk.
  t, out, N_PORTS: 1 = release (pad Z), 0 = drive low.
  owner, out, OW: index of the port currently holding the line low.
  busy, out, 1: FSM in OWNED.
  stuck, out, 1: FSM in STUCK.

Function
REQ-004 The tick SHALL come from a 0..DIV-1 counter; tick is high for one clk when the count equals DIV-1, then the count wraps to 0.
REQ-005 Each i[k] SHALL pass a 2-flop synchroniser, giving s[k].
REQ-006 Each port SHALL keep a filtered level f[k] and a 4-bit agreement counter:
  on a tick with s[k] != f[k], the counter increments; on reaching FILT, f[k] takes s[k] and the counter clears.
  on a tick with s[k] == f[k], the counter clears.
REQ-007 A disabled port (en[k]=0) SHALL have t[k]=1, SHALL never be granted ownership, and SHALL be ignored by every "all high" test.
REQ-008 FSM states SHALL be IDLE, OWNED, RELEASE and STUCK; the FSM changes state only on tick cycles.
REQ-009 IDLE: t all 1. If any enabled f[k]=0, the FSM SHALL move to OWNED with owner = lowest such k (lowest index wins on simultaneous lows).
REQ-010 OWNED: t[owner]=1 and t[j]=0 for every other enabled j. Lows on non-owner ports SHALL be ignored, since they are the bridge's own echo.
REQ-011 OWNED exit SHALL be to RELEASE when f[owner]=1 or en[owner]=0. It SHALL be to STUCK when TIMEOUT != 0 and the owner-low tick counter reaches TIMEOUT; RELEASE takes precedence on the same tick.
REQ-012 RELEASE: t all 1 and lows ignored for HOLD ticks, then IDLE.
REQ-013 STUCK: t all 1, stuck=1. Exit to IDLE on the first tick where all enabled f are 1.
REQ-014 t, owner, busy and stuck SHALL be registered and updated in the clk cycle after the FSM transition.
REQ-015 Latency from i[k] falling (stable, port enabled, FSM in IDLE) to t[j]=0 on the other ports SHALL be at most 2 + DIV*(FILT+1) + 1 clk.
REQ-016 owner SHALL hold its last value outside OWNED.
REQ-017 The owner-low tick counter SHALL clear on OWNED entry and saturate at TIMEOUT.

Reset
REQ-018 rst_n=0 SHALL immediately (asynchronously) force:
  t all 1, owner=0, busy=0, stuck=0, FSM=IDLE.
  sync flops and all f = 1, all counters 0.
REQ-019 Reset asserted mid-OWNED SHALL release all ports within the same clk cycle; after release the bridge SHALL start in IDLE.
REQ-020 Reset deassertion SHALL be synchronised internally; the first tick SHALL occur DIV clk after deassertion.

Verification
Bench parameters: N_PORTS=4, DIV=4, FILT=2, HOLD=3, TIMEOUT=16, en=4'b1111 unless stated otherwise.
REQ-021 Grant and release: i[2] low ->
  t=4'b0100 (t[2] released, others driven low), owner=2, busy=1, within 15 clk;
  i[2] high -> t=4'b1111, then busy=0, then IDLE after 3 ticks.
REQ-022 Simultaneous lows: i[3] and i[1] fall in the same cycle -> owner=1, t=4'b0010.
REQ-023 Glitch rejection: a 1-tick low pulse on i[0] -> t stays 4'b1111 and busy stays 0.
REQ-024 Timeout: i[0] held low for more than 16 ticks -> stuck=1 and t=4'b1111; i[0] released -> stuck=0 within FILT+1 ticks.
REQ-025 Disable mid-transfer: owner=2, then en[2] dropped -> RELEASE and t=4'b1111. With en=4'b1011, i[2] low -> no grant.
REQ-026 Reset mid-OWNED: rst_n pulsed low -> t=4'b1111 in the same cycle, owner=0, busy=0.

Source files
------------

// File: rtl/i2c_line_bridge_n.sv
// i2c_line_bridge_n
//   Joins N_PORTS open-drain segments of one I2C line (SDA or SCL). Each pad
//   level is synchronised and filtered. The first enabled port seen pulling
//   low becomes the owner, and the bridge then drives every other enabled
//   port low. When the owner lets go, all ports are released for HOLD ticks
//   so that the bridge's own echo can die away. If the owner stays low for
//   TIMEOUT ticks, the line is declared stuck and released until every
//   enabled port reads high again.
//
// Ports
//   clk    : single clock
//   rst_n  : asynchronous active-low reset (deassertion synchronised inside)
//   en     : per-port enable; a disabled port is always released and ignored
//   i      : pad levels, asynchronous to clk
//   t      : 1 = release pad (Z), 0 = drive pad low
//   owner  : index of the port holding the line (holds outside OWNED)
//   busy   : FSM in OWNED
//   stuck  : FSM in STUCK
module i2c_line_bridge_n #(
  parameter int N_PORTS = 2,
  parameter int DIV     = 6,
  parameter int FILT    = 2,
  parameter int HOLD    = 3,
  parameter int TIMEOUT = 4096,
  localparam int OW     = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] en,
  input  logic [N_PORTS-1:0] i,
  output logic [N_PORTS-1:0] t,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic               stuck
);

  localparam int CW = $clog2(DIV);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, RELEASE, STUCK} state_t;

  // Reset: assertion is immediate, release is aligned to clk
  logic [1:0] rst_sync;
  logic       rst_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  // Tick divider
  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // Pad synchronisers
  logic [N_PORTS-1:0] s_meta, s;

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      s_meta <= '1;
      s      <= '1;
    end else begin
      s_meta <= i;
      s      <= s_meta;
    end
  end

  // Agreement filters: a level change must be seen on FILT consecutive ticks
  logic [N_PORTS-1:0] f;
  logic [3:0]         fcnt [N_PORTS];

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      f <= '1;
      for (int k = 0; k < N_PORTS; k++) fcnt[k] <= 4'd0;
    end else if (tick) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (s[k] != f[k]) begin
          if (fcnt[k] + 4'd1 >= 4'(FILT)) begin
            f[k]    <= s[k];
            fcnt[k] <= 4'd0;
          end else begin
            fcnt[k] <= fcnt[k] + 4'd1;
          end
        end else begin
          fcnt[k] <= 4'd0;
        end
      end
    end
  end

  // Arbitration FSM
  state_t             state_q, state_d;
  logic [OW-1:0]      own_q, own_d, grant_idx;
  logic [N_PORTS-1:0] low_en;
  logic [TW-1:0]      tmo_q;
  logic [3:0]         hold_q;
  logic               tmo_hit, tmo_sat;

  assign low_en  = en & ~f;
  assign tmo_sat = (tmo_q == TW'(TIMEOUT));
  assign tmo_hit = (TIMEOUT != 0) &&
                   (({1'b0, tmo_q} + (TW+1)'(1)) >= (TW+1)'(TIMEOUT));

  // Descending scan so the lowest active index is the one that sticks
  always_comb begin
    grant_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (low_en[k]) grant_idx = OW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (|low_en) begin
            state_d = OWNED;
            own_d   = grant_idx;
          end
        end
        OWNED: begin
          // Release wins over timeout when both happen on the same tick
          if (f[own_q] || !en[own_q]) state_d = RELEASE;
          else if (tmo_hit)           state_d = STUCK;
        end
        RELEASE: begin
          if (hold_q == 4'(HOLD - 1)) state_d = IDLE;
        end
        STUCK: begin
          if (low_en == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state_q <= IDLE;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      tmo_q  <= '0;
      hold_q <= 4'd0;
    end else if (tick) begin
      if (state_q != OWNED && state_d == OWNED) tmo_q <= '0;
      else if (state_q == OWNED && !tmo_sat)    tmo_q <= tmo_q + TW'(1);
      if (state_q == RELEASE) hold_q <= hold_q + 4'd1;
      else                    hold_q <= 4'd0;
    end
  end

  // Registered outputs, one clk behind the state register
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      t     <= '1;
      owner <= '0;
      busy  <= 1'b0;
      stuck <= 1'b0;
    end else begin
      busy  <= (state_q == OWNED);
      stuck <= (state_q == STUCK);
      if (state_q == OWNED) begin
        owner <= own_q;
        t     <= ~en | (N_PORTS'(1) << own_q);
      end else begin
        t     <= '1;
      end
    end
  end

endmodule
